// File: rtl/cam_pkg.sv
// Shared definitions for the CAM readback block: array geometry, the
// subarray-to-bit map and the readback FSM state encoding.
package cam_pkg;

  // Array geometry
  localparam int CAM_ROWS = 36;
  localparam int CAM_COLS = 32;

  // Port widths
  localparam int ROW_W   = 6;
  localparam int COL_W   = 5;
  localparam int LEN_W   = 6;
  localparam int DATA_W  = 16;
  localparam int MAX_LEN = 32;

  // Bit map of rd_bits: one bit per subarray
  localparam int SIGN_BIT     = 15;
  localparam int EXP_BIT      = 14;
  localparam int MANT_FIRST_K = 2;
  localparam int MANT_LAST_K  = 15;

  // Readback FSM states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ISSUE   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_HOLD    = 3'd3,
    ST_FIN     = 3'd4
  } state_t;

  // rd_bits position driven by mantissa subarray instance k
  function automatic int mant_bit(input int k);
    return SIGN_BIT - k;
  endfunction

endpackage

// File: rtl/cam_rb_addr_gen.sv
// Row/column address counter for CAM readback. Loads a start address and
// steps column-first, wrapping column into row and row back to zero.
module cam_rb_addr_gen
  import cam_pkg::*;
#(
  parameter int ROWS = CAM_ROWS,
  parameter int COLS = CAM_COLS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [ROW_W-1:0] load_row,
  input  logic [COL_W-1:0] load_col,
  input  logic             step,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col
);

  // Address register: load wins over step; last cell wraps to (0,0)
  always_ff @(posedge clk) begin
    if (rst) begin
      row <= '0;
      col <= '0;
    end else if (load) begin
      row <= load_row;
      col <= load_col;
    end else if (step) begin
      if (col == COL_W'(COLS - 1)) begin
        col <= '0;
        if (row == ROW_W'(ROWS - 1)) begin
          row <= '0;
        end else begin
          row <= row + 1'b1;
        end
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cam_readback.sv
// CAM readback engine: reads req_len consecutive cells starting at
// (req_row, req_col) and presents each reassembled word on out_data.
// Optional feature macro: CAM_READBACK_PARITY_EN adds out_parity.
//
// Handshakes: a request transfers on a rising edge with req_valid=1 and
// req_ready=1 (req_ready is high only in IDLE); a word transfers on a
// rising edge with out_valid=1 and out_ready=1, and out_data holds
// steady while out_valid is high and out_ready is low.
module cam_readback
  import cam_pkg::*;
#(
  parameter int ROWS = CAM_ROWS,
  parameter int COLS = CAM_COLS
) (
  input  logic              CLK,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ROW_W-1:0]  req_row,
  input  logic [COL_W-1:0]  req_col,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rd_en,
  output logic [ROW_W-1:0]  rd_row,
  output logic [COL_W-1:0]  rd_col,
  input  logic [DATA_W-1:0] rd_bits,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              done,
  output logic              req_err,
`ifdef CAM_READBACK_PARITY_EN
  output logic              out_parity,
`endif
  output state_t            dbg_state
);

  state_t             state;
  logic [LEN_W-1:0]   remain;
  logic               accept;
  logic               illegal;
  logic               load;
  logic [DATA_W-1:0]  word;

  assign req_ready = (state == ST_IDLE);
  assign rd_en     = (state == ST_ISSUE);
  assign done      = (state == ST_FIN);
  assign dbg_state = state;

  assign accept  = req_valid && req_ready;
  assign illegal = (int'(req_row) >= ROWS) || (req_len > LEN_W'(MAX_LEN));
  assign load    = accept && !illegal;

  // Reassemble the word from the per-subarray bits
  always_comb begin
    word = '0;
    word[SIGN_BIT] = rd_bits[SIGN_BIT];
    word[EXP_BIT]  = rd_bits[EXP_BIT];
    for (int k = MANT_FIRST_K; k <= MANT_LAST_K; k++) begin
      word[mant_bit(k)] = rd_bits[mant_bit(k)];
    end
  end

  cam_rb_addr_gen #(
    .ROWS (ROWS),
    .COLS (COLS)
  ) u_addr_gen (
    .clk      (CLK),
    .rst      (rst),
    .load     (load),
    .load_row (req_row),
    .load_col (req_col),
    .step     (rd_en),
    .row      (rd_row),
    .col      (rd_col)
  );

  // Readback FSM with output word register and error pulse
  always_ff @(posedge CLK) begin
    if (rst) begin
      state     <= ST_IDLE;
      remain    <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      req_err   <= 1'b0;
    end else begin
      req_err <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (illegal) begin
              req_err <= 1'b1;
            end else if (req_len == '0) begin
              state <= ST_FIN;
            end else begin
              remain <= req_len;
              state  <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          remain <= remain - 1'b1;
          state  <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          out_data  <= word;
          out_valid <= 1'b1;
          state     <= ST_HOLD;
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= (remain == '0) ? ST_FIN : ST_ISSUE;
          end
        end
        ST_FIN: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef CAM_READBACK_PARITY_EN
  // Even parity of the captured bits, registered alongside out_data
  always_ff @(posedge CLK) begin
    if (rst) begin
      out_parity <= 1'b0;
    end else if (state == ST_CAPTURE) begin
      out_parity <= ^rd_bits;
    end
  end
`endif

endmodule

// File: doc/cam_readback.md
CAM_READBACK -- requirements
Module: cam_readback

Interface
REQ-001 SHALL have parameter ROWS, default 36, meaning the number of CAM subarray rows.
REQ-002 SHALL have parameter COLS, default 32, meaning the number of CAM subarray columns.
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: readback request strobe.
REQ-006 SHALL have port req_ready, output, 1 bit: high only in IDLE.
REQ-007 SHALL have port req_row, input, 6 bits: start row.
REQ-008 SHALL have port req_col, input, 5 bits: start column.
REQ-009 SHALL have port req_len, input, 6 bits: word count, legal 0..32.
REQ-010 SHALL have port rd_en, output, 1 bit: array read strobe.
REQ-011 SHALL have port rd_row, output, 6 bits: array read row.
REQ-012 SHALL have port rd_col, output, 5 bits: array read column.
REQ-013 SHALL have port rd_bits, input, 16 bits: one bit per subarray, valid one cycle after rd_en.
REQ-014 SHALL have port out_valid, output, 1 bit: reassembled word available.
REQ-015 SHALL have port out_ready, input, 1 bit: consumer accept.
REQ-016 SHALL have port out_data, output, 16 bits: reassembled word.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at transfer end.
REQ-018 SHALL have port req_err, output, 1 bit: one-cycle pulse on an illegal request.

Function
REQ-019 SHALL map bits as follows: rd_bits[15] from the sign subarray, rd_bits[14] from the exp subarray, and rd_bits[15-k] from mantissa subarray instance k (k=2..15).
REQ-020 SHALL implement FSM states IDLE, ISSUE, CAPTURE, HOLD, FIN.
REQ-021 SHALL accept a request in IDLE when req_valid=1 and req_ready=1.
REQ-022 SHALL, on an accepted request with req_row>=ROWS or req_len>32, pulse req_err for one cycle, remain in IDLE, and assert no rd_en.
REQ-023 SHALL, on an accepted request with req_len=0, go directly to FIN and assert no rd_en.
REQ-024 SHALL, in ISSUE, assert rd_en for exactly one cycle with the current row and column, then enter CAPTURE.
REQ-025 SHALL, in CAPTURE, register rd_bits into out_data, set out_valid, and enter HOLD.
REQ-026 SHALL, in HOLD, keep out_data stable and out_valid high until out_ready=1, then clear out_valid and go to ISSUE if words remain, otherwise to FIN.
REQ-027 SHALL present the first word three cycles after acceptance (accept, ISSUE, CAPTURE) and sustain one word per three cycles with out_ready held high.
REQ-028 SHALL advance the address by column+1; column COLS-1 wraps to 0 with row+1; row ROWS-1 at column COLS-1 wraps to row 0, column 0.
REQ-029 SHALL, in FIN, pulse done for one cycle and return to IDLE.
REQ-030 SHALL ignore req_valid outside IDLE.

Reset
REQ-031 SHALL, on rst=1 at any state, enter IDLE on the next edge, with outputs rd_en=0, out_valid=0, out_data=0, done=0, req_err=0, req_ready=1, rd_row=0, rd_col=0, and discard any in-flight word.

Configuration
REQ-032 SHALL, when macro CAM_READBACK_PARITY_EN is defined, add output out_parity (1 bit, even parity of rd_bits, registered with out_data, reset 0).
REQ-033 SHALL, when CAM_READBACK_PARITY_EN is undefined, not have port out_parity, with all other behaviour identical.

Structure
REQ-034 SHALL place the ROWS/COLS defaults, the bit-map index constants, and the FSM state typedef in shared package cam_pkg.
REQ-035 SHALL implement the row/column counter and wrap logic in sub-module cam_rb_addr_gen.

Verification
REQ-036 SHALL test a simple readback: array (0,0)=16'hE26F, req_row=0, req_col=0, req_len=1 -> single rd_en at (0,0), out_data=16'hE26F 3 cycles after accept, done pulse after the handshake.
REQ-037 SHALL test column wrap: req_row=2, req_col=31, req_len=2 -> rd_en at (2,31) then (3,0).
REQ-038 SHALL test row wrap: req_row=35, req_col=31, req_len=2 -> rd_en at (35,31) then (0,0).
REQ-039 SHALL test backpressure: out_ready low 5 cycles -> out_data stable, out_valid held, no extra rd_en.
REQ-040 SHALL test illegal requests: req_row=36 or req_len=33 -> req_err one cycle, no rd_en, req_ready stays 1.
REQ-041 SHALL test reset mid-transfer: rst during HOLD of a len=4 transfer -> next cycle out_valid=0, req_ready=1, no done pulse.
